// File: rtl/pcileech_wifi_link_pkg.sv
// pcileech_wifi_link_pkg
//   Shared definitions for the Wi-Fi link-layer BAR responder: FSM state codes,
//   register offsets (word index, i.e. byte address [7:2]), STATUS/CTRL bit
//   positions, the CTRL command layout, the auto-connect sequencer states and a
//   saturating counter helper.
package pcileech_wifi_link_pkg;

  // Link FSM state encoding (visible in STATUS[2:0]).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SCANNING  = 3'd1;
  localparam logic [2:0] ST_AUTH      = 3'd2;
  localparam logic [2:0] ST_ASSOC     = 3'd3;
  localparam logic [2:0] ST_CONNECTED = 3'd4;

  // Register word offsets.
  localparam logic [5:0] REG_CTRL       = 6'h00;
  localparam logic [5:0] REG_SEL        = 6'h01;
  localparam logic [5:0] REG_STATUS     = 6'h02;
  localparam logic [5:0] REG_RSSI       = 6'h03;
  localparam logic [5:0] REG_SCAN_COUNT = 6'h04;
  localparam logic [5:0] REG_SCAN_IDX   = 6'h05;
  localparam logic [5:0] REG_SCAN_SSID  = 6'h06;
  localparam logic [5:0] REG_SCAN_RSSI  = 6'h07;
  localparam logic [5:0] REG_EVENTS     = 6'h08;

  // STATUS bit positions.
  localparam int STS_LINK_UP   = 8;
  localparam int STS_AUTH_FAIL = 9;
  localparam int STS_SCAN_DONE = 10;
  localparam int STS_IDX_LSB   = 16;
  localparam int STS_ROAM_LSB  = 24;

  // CTRL write layout: b0 CONNECT, b1 DISCONNECT, b2 SCAN.
  typedef struct packed {
    logic scan;
    logic disconnect;
    logic connect;
  } ctrl_cmd_t;

  // Post-reset auto-connect sequencer.
  typedef enum logic [1:0] {
    AUTO_OFF  = 2'd0,
    AUTO_SCAN = 2'd1,
    AUTO_CONN = 2'd2
  } auto_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pcileech_bar_impl_wifi_link_sim_rssi_gen.sv
// pcileech_wifi_rssi_gen
//   Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1)
//   plus an RSSI update period counter that only runs while enabled.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   en     in  link is CONNECTED; period counter held at 0 otherwise
//   upd    out one-cycle strobe every RSSI_PERIOD enabled cycles
//   jitter out low three LFSR bits, subtracted from the base RSSI
module pcileech_wifi_rssi_gen #(
  parameter int RSSI_PERIOD = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       upd,
  output logic [2:0] jitter
);

  localparam int CW = (RSSI_PERIOD > 1) ? $clog2(RSSI_PERIOD) : 1;

  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] per_q, per_d;
  logic          per_end;

  assign per_end = (per_q == CW'(RSSI_PERIOD - 1));

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    per_d  = per_q;
    if (!en || per_end) per_d = '0;
    else                per_d = per_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
      per_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      per_q  <= per_d;
    end
  end

  assign upd    = en && per_end;
  assign jitter = lfsr_q[2:0];

endmodule

// File: rtl/pcileech_bar_impl_wifi_link_sim.sv
// pcileech_bar_impl_wifi_link_sim
//   BAR responder emulating a Wi-Fi adapter's link layer: host-driven
//   scan/connect/disconnect FSM over NUM_NETS modelled networks, per-network
//   auth lockout, LFSR-jittered RSSI and saturating link event counters.
//   Optional feature macro: WIFI_LINK_ROAM_EN (RSSI-triggered roaming and a
//   roam counter in STATUS[31:24]); undefined by default.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_addr/wr_be/wr_data     write byte address (decode [7:2]), byte enables, data
//   wr_valid                  write strobe
//   rd_req_ctx/addr/valid     read request (context echoed back)
//   rd_rsp_ctx/data/valid     registered read response, one cycle after request
module pcileech_bar_impl_wifi_link_sim
  import pcileech_wifi_link_pkg::*;
#(
  parameter int                      NUM_NETS     = 4,
  parameter logic [NUM_NETS*32-1:0]  SSID_TABLE   = {"Free", "Boss", "Cafe", "Home"},
  parameter logic [NUM_NETS*8-1:0]   RSSI_TABLE   = {8'd50, 8'd60, 8'd75, 8'd90},
  parameter logic [NUM_NETS-1:0]     LOCKED_MASK  = 4'b0100,
  parameter int                      T_SCAN       = 1000,
  parameter int                      T_AUTH       = 500,
  parameter int                      T_ASSOC      = 500,
  parameter int                      RSSI_PERIOD  = 256,
  parameter int                      AUTO_CONNECT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  input  logic [87:0] rd_req_ctx,
  input  logic [31:0] rd_req_addr,
  input  logic        rd_req_valid,
  output logic [87:0] rd_rsp_ctx,
  output logic [31:0] rd_rsp_data,
  output logic        rd_rsp_valid
);

  localparam logic [4:0] NN = 5'(NUM_NETS);

  // Table lookups by loop so an index never selects past the packed tables.
  function automatic logic [31:0] ssid_at(input logic [3:0] idx);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NUM_NETS; i++)
      if (idx == 4'(i)) r = SSID_TABLE[32*i +: 32];
    return r;
  endfunction

  function automatic logic [7:0] base_at(input logic [3:0] idx);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NUM_NETS; i++)
      if (idx == 4'(i)) r = RSSI_TABLE[8*i +: 8];
    return r;
  endfunction

  function automatic logic locked_at(input logic [3:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_NETS; i++)
      if (idx == 4'(i)) r = LOCKED_MASK[i];
    return r;
  endfunction

`ifdef WIFI_LINK_ROAM_EN
  // {found, index}: strongest-base unlocked network other than cur, lowest index on ties.
  function automatic logic [4:0] pick_roam(input logic [3:0] cur);
    logic       found;
    logic [3:0] best;
    logic [7:0] best_r;
    found  = 1'b0;
    best   = '0;
    best_r = '0;
    for (int i = 0; i < NUM_NETS; i++) begin
      if (4'(i) != cur && !LOCKED_MASK[i] && (!found || RSSI_TABLE[8*i +: 8] > best_r)) begin
        found  = 1'b1;
        best   = 4'(i);
        best_r = RSSI_TABLE[8*i +: 8];
      end
    end
    return {found, best};
  endfunction
`endif

  // Architectural state.
  logic [2:0]  state_q, state_d;
  logic [31:0] dwell_q, dwell_d;
  logic [7:0]  sel_q, sel_d;
  logic [3:0]  scan_idx_q, scan_idx_d;
  logic [3:0]  target_q, target_d;
  logic [3:0]  conn_idx_q, conn_idx_d;
  logic [7:0]  rssi_q, rssi_d;
  logic [15:0] connects_q, connects_d;
  logic [15:0] drops_q, drops_d;
  logic        scan_done_q, scan_done_d;
  logic        auth_fail_q, auth_fail_d;
  auto_e       auto_q, auto_d;
`ifdef WIFI_LINK_ROAM_EN
  logic [1:0]  low_cnt_q, low_cnt_d;
  logic [7:0]  roam_cnt_q, roam_cnt_d;
  logic [4:0]  roam_pick;
`endif

  // Read response registers.
  logic [87:0] rsp_ctx_q;
  logic [31:0] rsp_data_q, rd_data;
  logic        rsp_vld_q;

  // Decode.
  logic        wr_ctrl, wr_sel, wr_scan_idx, rd_scan_ssid;
  ctrl_cmd_t   cmd;
  logic        do_disc, do_conn, do_scan, sel_ok, enter;
  logic        link_up, rssi_upd;
  logic [2:0]  rssi_jitter;
  logic [7:0]  cur_base, new_rssi;
  logic [31:0] status_word;

  assign wr_ctrl      = wr_valid && (wr_addr[7:2] == REG_CTRL) && wr_be[0];
  assign wr_sel       = wr_valid && (wr_addr[7:2] == REG_SEL) && wr_be[0];
  assign wr_scan_idx  = wr_valid && (wr_addr[7:2] == REG_SCAN_IDX) && wr_be[0];
  assign rd_scan_ssid = rd_req_valid && (rd_req_addr[7:2] == REG_SCAN_SSID);
  assign cmd          = wr_ctrl ? ctrl_cmd_t'(wr_data[2:0]) : ctrl_cmd_t'(3'b000);

  assign link_up  = (state_q == ST_CONNECTED);
  assign sel_ok   = (sel_q < 8'(NUM_NETS));
  assign cur_base = base_at(conn_idx_q);
  assign new_rssi = cur_base - {5'd0, rssi_jitter};

  // DISCONNECT has priority; CONNECT only in IDLE/CONNECTED; SCAN only in IDLE.
  assign do_disc = cmd.disconnect;
  assign do_conn = !do_disc && cmd.connect && (state_q == ST_IDLE || state_q == ST_CONNECTED);
  assign do_scan = !do_disc && !do_conn && cmd.scan && (state_q == ST_IDLE);

`ifdef WIFI_LINK_ROAM_EN
  assign roam_pick = pick_roam(conn_idx_q);
`endif

  pcileech_wifi_rssi_gen #(
    .RSSI_PERIOD(RSSI_PERIOD)
  ) u_rssi (
    .clk    (clk),
    .rst    (rst),
    .en     (link_up),
    .upd    (rssi_upd),
    .jitter (rssi_jitter)
  );

  // Register writes and the SCAN_SSID post-increment (an explicit write wins).
  always_comb begin
    sel_d      = sel_q;
    scan_idx_d = scan_idx_q;
    if (wr_sel) sel_d = wr_data[7:0];
    if (rd_scan_ssid)
      scan_idx_d = ({1'b0, scan_idx_q} == NN - 5'd1) ? 4'd0 : scan_idx_q + 4'd1;
    if (wr_scan_idx)
      scan_idx_d = ({1'b0, wr_data[3:0]} >= NN) ? 4'd0 : wr_data[3:0];
  end

  // Link FSM.
  always_comb begin
    state_d     = state_q;
    enter       = 1'b0;
    target_d    = target_q;
    conn_idx_d  = conn_idx_q;
    rssi_d      = rssi_q;
    connects_d  = connects_q;
    drops_d     = drops_q;
    scan_done_d = scan_done_q;
    auth_fail_d = auth_fail_q;
    auto_d      = auto_q;
`ifdef WIFI_LINK_ROAM_EN
    low_cnt_d   = low_cnt_q;
    roam_cnt_d  = roam_cnt_q;
`endif
    if (do_disc) begin
      if (link_up) drops_d = sat_inc16(drops_q);
      state_d = ST_IDLE;
      enter   = 1'b1;
      auto_d  = AUTO_OFF;
    end else if (do_conn) begin
      auto_d = AUTO_OFF;
      if (sel_ok) begin
        target_d    = sel_q[3:0];
        auth_fail_d = 1'b0;
        state_d     = ST_AUTH;
        enter       = 1'b1;
      end else begin
        auth_fail_d = 1'b1;
      end
    end else if (do_scan) begin
      state_d = ST_SCANNING;
      enter   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (auto_q == AUTO_SCAN) begin
            state_d = ST_SCANNING;
            enter   = 1'b1;
            auto_d  = AUTO_CONN;
          end else if (auto_q == AUTO_CONN) begin
            target_d    = 4'd0;
            auth_fail_d = 1'b0;
            state_d     = ST_AUTH;
            enter       = 1'b1;
            auto_d      = AUTO_OFF;
          end
        end
        ST_SCANNING: begin
          if (dwell_q == 32'(T_SCAN - 1)) begin
            scan_done_d = 1'b1;
            state_d     = ST_IDLE;
            enter       = 1'b1;
          end
        end
        ST_AUTH: begin
          if (dwell_q == 32'(T_AUTH - 1)) begin
            enter = 1'b1;
            if (locked_at(target_q)) begin
              auth_fail_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_ASSOC;
            end
          end
        end
        ST_ASSOC: begin
          if (dwell_q == 32'(T_ASSOC - 1)) begin
            state_d    = ST_CONNECTED;
            enter      = 1'b1;
            connects_d = sat_inc16(connects_q);
            conn_idx_d = target_q;
            rssi_d     = base_at(target_q);
`ifdef WIFI_LINK_ROAM_EN
            low_cnt_d  = '0;
`endif
          end
        end
        ST_CONNECTED: begin
          if (rssi_upd) begin
            rssi_d = new_rssi;
`ifdef WIFI_LINK_ROAM_EN
            // Fourth consecutive weak update triggers a roam if any candidate exists;
            // otherwise the count holds so each further weak update retries.
            if (new_rssi < cur_base - 8'd4) begin
              if (low_cnt_q == 2'd3) begin
                if (roam_pick[4]) begin
                  drops_d    = sat_inc16(drops_q);
                  target_d   = roam_pick[3:0];
                  state_d    = ST_AUTH;
                  enter      = 1'b1;
                  low_cnt_d  = '0;
                  roam_cnt_d = (roam_cnt_q == 8'hFF) ? roam_cnt_q : roam_cnt_q + 8'd1;
                end
              end else begin
                low_cnt_d = low_cnt_q + 2'd1;
              end
            end else begin
              low_cnt_d = '0;
            end
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
          enter   = 1'b1;
        end
      endcase
    end
    dwell_d = enter ? 32'd0 : dwell_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dwell_q     <= '0;
      sel_q       <= '0;
      scan_idx_q  <= '0;
      target_q    <= '0;
      conn_idx_q  <= '0;
      rssi_q      <= '0;
      connects_q  <= '0;
      drops_q     <= '0;
      scan_done_q <= 1'b0;
      auth_fail_q <= 1'b0;
      auto_q      <= (AUTO_CONNECT != 0) ? AUTO_SCAN : AUTO_OFF;
`ifdef WIFI_LINK_ROAM_EN
      low_cnt_q   <= '0;
      roam_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      sel_q       <= sel_d;
      scan_idx_q  <= scan_idx_d;
      target_q    <= target_d;
      conn_idx_q  <= conn_idx_d;
      rssi_q      <= rssi_d;
      connects_q  <= connects_d;
      drops_q     <= drops_d;
      scan_done_q <= scan_done_d;
      auth_fail_q <= auth_fail_d;
      auto_q      <= auto_d;
`ifdef WIFI_LINK_ROAM_EN
      low_cnt_q   <= low_cnt_d;
      roam_cnt_q  <= roam_cnt_d;
`endif
    end
  end

  always_comb begin
    status_word                  = '0;
    status_word[2:0]             = state_q;
    status_word[STS_LINK_UP]     = link_up;
    status_word[STS_AUTH_FAIL]   = auth_fail_q;
    status_word[STS_SCAN_DONE]   = scan_done_q;
    status_word[STS_IDX_LSB +: 8] = {4'd0, conn_idx_q};
`ifdef WIFI_LINK_ROAM_EN
    status_word[STS_ROAM_LSB +: 8] = roam_cnt_q;
`endif
  end

  // Read mux over current state, so a same-cycle write is seen only by later reads.
  always_comb begin
    rd_data = '0;
    unique case (rd_req_addr[7:2])
      REG_SEL:        rd_data = {24'd0, sel_q};
      REG_STATUS:     rd_data = status_word;
      REG_RSSI:       rd_data = link_up ? {24'd0, rssi_q} : 32'd0;
      REG_SCAN_COUNT: rd_data = scan_done_q ? 32'(NUM_NETS) : 32'd0;
      REG_SCAN_IDX:   rd_data = {28'd0, scan_idx_q};
      REG_SCAN_SSID:  rd_data = ssid_at(scan_idx_q);
      REG_SCAN_RSSI:  rd_data = {24'd0, base_at(scan_idx_q)};
      REG_EVENTS:     rd_data = {drops_q, connects_q};
      default:        rd_data = '0;
    endcase
  end

  // Response stage: one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_ctx_q  <= '0;
    end else begin
      rsp_vld_q  <= rd_req_valid;
      rsp_data_q <= rd_req_valid ? rd_data : 32'd0;
      rsp_ctx_q  <= rd_req_valid ? rd_req_ctx : 88'd0;
    end
  end

  assign rd_rsp_valid = rsp_vld_q;
  assign rd_rsp_data  = rsp_data_q;
  assign rd_rsp_ctx   = rsp_ctx_q;

  logic unused_bits;
  assign unused_bits = ^{wr_addr[31:8], wr_addr[1:0], wr_be[3:1], wr_data[31:8],
                         rd_req_addr[31:8], rd_req_addr[1:0]};

endmodule

// File: tb/tb_pcileech_bar_impl_wifi_link_sim.sv
module tb_pcileech_bar_impl_wifi_link_sim;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic [87:0] rd_req_ctx = '0;
  logic [31:0] rd_req_addr = '0;
  logic        rd_req_valid = 1'b0;
  logic [87:0] rd_rsp_ctx;
  logic [31:0] rd_rsp_data;
  logic        rd_rsp_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;

  localparam logic [31:0] A_CTRL = 32'h00, A_SEL = 32'h04, A_STATUS = 32'h08, A_RSSI = 32'h0C,
                          A_SCNT = 32'h10, A_SIDX = 32'h14, A_SSID = 32'h18, A_SRSSI = 32'h1C,
                          A_EVENTS = 32'h20;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcileech_bar_impl_wifi_link_sim dut (
    .clk          (clk),
    .rst          (rst),
    .wr_addr      (wr_addr),
    .wr_be        (wr_be),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .rd_req_ctx   (rd_req_ctx),
    .rd_req_addr  (rd_req_addr),
    .rd_req_valid (rd_req_valid),
    .rd_rsp_ctx   (rd_rsp_ctx),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_valid (rd_rsp_valid)
  );

  // Single read; returns X when no response pulse arrived so the caller's compare fails.
  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    rd_req_addr  = addr;
    rd_req_ctx   = 88'h5A;
    rd_req_valid = 1'b1;
    @(negedge clk);
    rd_req_valid = 1'b0;
    data = rd_rsp_valid ? rd_rsp_data : 32'hxxxxxxxx;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    @(negedge clk);
    wr_addr  = addr;
    wr_be    = be;
    wr_data  = data;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge clk);
    rd_req_addr  = A_STATUS;
    rd_req_ctx   = 88'hABCDEF;
    rd_req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_rsp_valid, rd_rsp_data, rd_rsp_ctx} !== 121'd0) begin
      failures++;
      $display("FAIL reset_outputs got vld=%b data=%h ctx=%h exp all zero", rd_rsp_valid, rd_rsp_data, rd_rsp_ctx);
    end
    rd_req_valid = 1'b0;
    rst = 1'b0;
    c0 = cyc;
    rd(A_STATUS, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'h1); end
    rd(A_SEL, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_sel got=%h exp=0", v); end
    rd(A_SIDX, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_scan_idx got=%h exp=0", v); end
    rd(A_EVENTS, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_events got=%h exp=0", v); end
    rd(A_SCNT, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_scan_count got=%h exp=0", v); end
    rd(A_RSSI, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_rssi got=%h exp=0", v); end
  endtask

  task automatic test_auto_connect();
    logic [2:0]  last, st;
    logic [14:0] acc;
    int          nseq, link_cyc;
    logic        done;
    logic [31:0] v;
    last = 3'd7; acc = '0; nseq = 0; done = 1'b0; link_cyc = 0;
    @(negedge clk);
    rd_req_addr  = A_STATUS;
    rd_req_valid = 1'b1;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (rd_rsp_valid) begin
        st = rd_rsp_data[2:0];
        if (st != last) begin
          acc  = {acc[11:0], st};
          nseq++;
          last = st;
        end
        if (st == 3'd4) begin
          done     = 1'b1;
          link_cyc = cyc - c0;
        end
      end
    end
    rd_req_valid = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL auto_link_timeout got link_up=0 exp=1"); end
    checks++;
    if (nseq != 5 || acc !== 15'b001_000_010_011_100) begin
      failures++; $display("FAIL auto_state_seq got n=%0d seq=%o exp n=5 seq=10234", nseq, acc);
    end
    checks++;
    if (link_cyc < 1995 || link_cyc > 2010) begin
      failures++; $display("FAIL auto_link_time got=%0d exp=1995..2010", link_cyc);
    end
    rd(A_STATUS, v);
    checks++; if (v !== 32'h504) begin failures++; $display("FAIL auto_status got=%h exp=%h", v, 32'h504); end
    rd(A_EVENTS, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL auto_events got=%h exp=%h", v, 32'h1); end
    rd(A_RSSI, v);
    checks++; if (v !== 32'h5A) begin failures++; $display("FAIL auto_rssi got=%h exp=%h", v, 32'h5A); end
    rd(A_SCNT, v);
    checks++; if (v !== 32'h4) begin failures++; $display("FAIL auto_scan_count got=%h exp=4", v); end
  endtask

  task automatic test_locked();
    logic [31:0] v;
    wr(A_SEL, 4'hF, 32'h2);
    wr(A_CTRL, 4'hF, 32'h1);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h402) begin failures++; $display("FAIL locked_in_auth got=%h exp=%h", v, 32'h402); end
    repeat (520) @(negedge clk);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h600) begin failures++; $display("FAIL locked_status got=%h exp=%h", v, 32'h600); end
    rd(A_EVENTS, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL locked_events got=%h exp=%h", v, 32'h1); end
    rd(A_RSSI, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL locked_rssi got=%h exp=0", v); end
    rd(A_CTRL, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL ctrl_reads_zero got=%h exp=0", v); end
  endtask

  task automatic test_scan_table();
    logic [31:0] v;
    wr(A_SIDX, 4'hF, 32'h3);
    rd(A_SSID, v);
    checks++; if (v !== 32'h46726565) begin failures++; $display("FAIL ssid_3 got=%h exp=%h", v, 32'h46726565); end
    rd(A_SSID, v);
    checks++; if (v !== 32'h486F6D65) begin failures++; $display("FAIL ssid_wrap0 got=%h exp=%h", v, 32'h486F6D65); end
    rd(A_SSID, v);
    checks++; if (v !== 32'h43616665) begin failures++; $display("FAIL ssid_1 got=%h exp=%h", v, 32'h43616665); end
    rd(A_SIDX, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL scan_idx_incr got=%h exp=2", v); end
    rd(A_SRSSI, v);
    checks++; if (v !== 32'h3C) begin failures++; $display("FAIL scan_rssi_2 got=%h exp=%h", v, 32'h3C); end
    rd(A_SRSSI, v);
    checks++; if (v !== 32'h3C) begin failures++; $display("FAIL scan_rssi_noinc got=%h exp=%h", v, 32'h3C); end
    wr(A_SIDX, 4'hF, 32'h9);
    rd(A_SIDX, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL scan_idx_clamp got=%h exp=0", v); end
    wr(A_SEL, 4'h0, 32'h55);
    rd(A_SEL, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL sel_be0 got=%h exp=2", v); end
    wr(A_SEL, 4'h1, 32'hFFFFFF01);
    rd(A_SEL, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL sel_be1 got=%h exp=1", v); end
  endtask

  task automatic test_disconnect();
    logic [31:0] v;
    wr(A_CTRL, 4'hF, 32'h1);
    repeat (1010) @(negedge clk);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h00010504) begin failures++; $display("FAIL conn1_status got=%h exp=%h", v, 32'h00010504); end
    rd(A_EVENTS, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL conn1_events got=%h exp=2", v); end
    repeat (300) @(negedge clk);
    rd(A_RSSI, v);
    checks++;
    if (v === 32'hx || v < 32'd68 || v > 32'd75) begin
      failures++; $display("FAIL rssi_jitter_range got=%h exp=44..4b", v);
    end
    wr(A_CTRL, 4'hF, 32'h3);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h00010400) begin failures++; $display("FAIL disc_status got=%h exp=%h", v, 32'h00010400); end
    rd(A_EVENTS, v);
    checks++; if (v !== 32'h00010002) begin failures++; $display("FAIL disc_events got=%h exp=%h", v, 32'h00010002); end
    rd(A_RSSI, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL disc_rssi got=%h exp=0", v); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rd_req_addr = A_RSSI; rd_req_ctx = 88'hAA_1111_2222_3333_4444_5555; rd_req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_ctx !== 88'hAA_1111_2222_3333_4444_5555 || rd_rsp_data !== 32'h0) begin
      failures++; $display("FAIL b2b_first got vld=%b ctx=%h data=%h", rd_rsp_valid, rd_rsp_ctx, rd_rsp_data);
    end
    rd_req_addr = 32'h44; rd_req_ctx = 88'h55_9999_8888_7777_6666_0001;
    @(negedge clk);
    checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_ctx !== 88'h55_9999_8888_7777_6666_0001 || rd_rsp_data !== 32'h0) begin
      failures++; $display("FAIL b2b_second got vld=%b ctx=%h data=%h", rd_rsp_valid, rd_rsp_ctx, rd_rsp_data);
    end
    rd_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse_end got vld=%b exp=0", rd_rsp_valid); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] v;
    wr(A_SIDX, 4'hF, 32'h1);
    @(negedge clk);
    rd_req_addr = A_SSID; rd_req_valid = 1'b1;
    wr_addr = A_SIDX; wr_be = 4'hF; wr_data = 32'h3; wr_valid = 1'b1;
    @(negedge clk);
    rd_req_valid = 1'b0; wr_valid = 1'b0;
    checks++; if (rd_rsp_data !== 32'h43616665) begin failures++; $display("FAIL same_ssid got=%h exp=%h", rd_rsp_data, 32'h43616665); end
    rd(A_SIDX, v);
    checks++; if (v !== 32'h3) begin failures++; $display("FAIL same_idx_wins got=%h exp=3", v); end
    @(negedge clk);
    rd_req_addr = A_SEL; rd_req_valid = 1'b1;
    wr_addr = A_SEL; wr_be = 4'hF; wr_data = 32'h7; wr_valid = 1'b1;
    @(negedge clk);
    rd_req_valid = 1'b0; wr_valid = 1'b0;
    checks++; if (rd_rsp_data !== 32'h1) begin failures++; $display("FAIL same_sel_old got=%h exp=1", rd_rsp_data); end
    rd(A_SEL, v);
    checks++; if (v !== 32'h7) begin failures++; $display("FAIL same_sel_new got=%h exp=7", v); end
  endtask

  task automatic test_scan_cmd();
    logic [31:0] v;
    wr(A_SEL, 4'hF, 32'h0);
    wr(A_CTRL, 4'hF, 32'h4);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h00010401) begin failures++; $display("FAIL scan_cmd got=%h exp=%h", v, 32'h00010401); end
    wr(A_CTRL, 4'hF, 32'h1);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h00010401) begin failures++; $display("FAIL conn_in_scan got=%h exp=%h", v, 32'h00010401); end
    repeat (1010) @(negedge clk);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h00010400) begin failures++; $display("FAIL scan_done_idle got=%h exp=%h", v, 32'h00010400); end
    wr(A_SEL, 4'hF, 32'h5);
    wr(A_CTRL, 4'hF, 32'h1);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h00010600) begin failures++; $display("FAIL sel_range got=%h exp=%h", v, 32'h00010600); end
    wr(A_SEL, 4'hF, 32'h0);
    wr(A_CTRL, 4'hF, 32'h7);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h00010600) begin failures++; $display("FAIL disc_priority got=%h exp=%h", v, 32'h00010600); end
    rd(A_EVENTS, v);
    checks++; if (v !== 32'h00010002) begin failures++; $display("FAIL idle_disc_events got=%h exp=%h", v, 32'h00010002); end
  endtask

`ifdef WIFI_LINK_ROAM_EN
  task automatic test_roam();
    logic [31:0] v;
    logic        seen;
    wr(A_SEL, 4'hF, 32'h0);
    wr(A_CTRL, 4'hF, 32'h1);
    repeat (1010) @(negedge clk);
    force dut.rssi_jitter = 3'd7;
    seen = 1'b0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      rd(A_STATUS, v);
      if (v[2:0] == 3'd2) seen = 1'b1;
    end
    release dut.rssi_jitter;
    checks++; if (!seen) begin failures++; $display("FAIL roam_timeout got state=%h exp=2", v[2:0]); end
    repeat (1010) @(negedge clk);
    rd(A_STATUS, v);
    checks++; if (v !== 32'h01010504) begin failures++; $display("FAIL roam_status got=%h exp=%h", v, 32'h01010504); end
    rd(A_EVENTS, v);
    checks++; if (v !== 32'h00020004) begin failures++; $display("FAIL roam_events got=%h exp=%h", v, 32'h00020004); end
  endtask
`endif

  initial begin
    test_reset();
    test_auto_connect();
    test_locked();
    test_scan_table();
    test_disconnect();
    test_back_to_back();
    test_same_cycle();
    test_scan_cmd();
`ifdef WIFI_LINK_ROAM_EN
    test_roam();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
